// File: rtl/exe_pkg.sv
// Shared types and constants for the SPI execution-unit frame receiver.
// The frame length helper is used by the receiver and by anything that builds frames.
package exe_pkg;

  localparam int DEF_BITS     = 8;
  localparam int DEF_OPC_BITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    ARG_A,
    ARG_B,
    HOLD
  } exe_rx_state_t;

  function automatic int frame_len(input int bits, input int opc_bits);
    return opc_bits + 2 * bits;
  endfunction

endpackage

// File: rtl/exe_sipo.sv
// Serial-in/parallel-out field register: shifts MSB first while enabled and
// copies the (possibly just-shifted) word into a held output on load.
module exe_sipo #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_shift_en,
  input  logic         i_sdi,
  input  logic         i_load_en,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_shift;
  logic [W-1:0] r_data;
  logic [W-1:0] w_shifted;
  logic [W-1:0] w_load_val;

  generate
    if (W == 1) begin : g_one
      assign w_shifted = i_sdi;
    end else begin : g_many
      assign w_shifted = {r_shift[W-2:0], i_sdi};
    end
  endgenerate

  // The last bit of a field may arrive on the load edge; fold it in directly.
  assign w_load_val = i_shift_en ? w_shifted : r_shift;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_data  <= '0;
    end else begin
      if (i_shift_en) r_shift <= w_shifted;
      if (i_load_en)  r_data  <= w_load_val;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/exe_frame_rx.sv
// Serial command-frame receiver: collects opcode, A and B (MSB first) and
// presents them under valid/ready; aborted or overrun frames pulse o_frame_err.
module exe_frame_rx
  import exe_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int OPC_BITS = DEF_OPC_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cs_n,
  input  logic                i_bit_en,
  input  logic                i_sdi,
  output logic [OPC_BITS-1:0] o_opcode,
  output logic [BITS-1:0]     o_argA,
  output logic [BITS-1:0]     o_argB,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_frame_err
);

  localparam int CNT_W = $clog2(((BITS > OPC_BITS) ? BITS : OPC_BITS) + 1);
  localparam logic [CNT_W-1:0] OPC_LAST = CNT_W'(OPC_BITS - 1);
  localparam logic [CNT_W-1:0] ARG_LAST = CNT_W'(BITS - 1);

  // A one-bit opcode is complete after its first bit, so the frame starts in ARG_A.
  localparam exe_rx_state_t    START_STATE = (OPC_BITS == 1) ? ARG_A : OPCODE;
  localparam logic [CNT_W-1:0] START_CNT   = (OPC_BITS == 1) ? '0 : CNT_W'(1);

  exe_rx_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_frame_err;

  logic w_acc;
  logic w_hs;
  logic w_start;
  logic w_shift_op;
  logic w_shift_a;
  logic w_shift_b;
  logic w_done;

  assign w_acc      = i_bit_en && !i_cs_n;
  assign w_hs       = r_valid && i_ready;
  assign w_start    = w_acc && ((r_state == IDLE) || ((r_state == HOLD) && w_hs));
  assign w_shift_op = w_start || ((r_state == OPCODE) && w_acc);
  assign w_shift_a  = (r_state == ARG_A) && w_acc;
  assign w_shift_b  = (r_state == ARG_B) && w_acc;
  assign w_done     = w_shift_b && (r_cnt == ARG_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_state <= START_STATE;
            r_cnt   <= START_CNT;
          end
        end

        OPCODE: begin
          if (i_cs_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_frame_err <= 1'b1;
          end else if (w_acc) begin
            if (r_cnt == OPC_LAST) begin
              r_state <= ARG_A;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        ARG_A: begin
          if (i_cs_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_frame_err <= 1'b1;
          end else if (w_acc) begin
            if (r_cnt == ARG_LAST) begin
              r_state <= ARG_B;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        ARG_B: begin
          if (i_cs_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_frame_err <= 1'b1;
          end else if (w_acc) begin
            if (r_cnt == ARG_LAST) begin
              r_state <= HOLD;
              r_cnt   <= '0;
              r_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        HOLD: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            if (w_acc) begin
              r_state <= START_STATE;
              r_cnt   <= START_CNT;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_acc) begin
            // Bit arrived while the previous frame is still unclaimed: drop it.
            r_frame_err <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  exe_sipo #(.W(OPC_BITS)) u_sipo_op (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_shift_en (w_shift_op),
    .i_sdi      (i_sdi),
    .i_load_en  (w_done),
    .o_data     (o_opcode)
  );

  exe_sipo #(.W(BITS)) u_sipo_a (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_shift_en (w_shift_a),
    .i_sdi      (i_sdi),
    .i_load_en  (w_done),
    .o_data     (o_argA)
  );

  exe_sipo #(.W(BITS)) u_sipo_b (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_shift_en (w_shift_b),
    .i_sdi      (i_sdi),
    .i_load_en  (w_done),
    .o_data     (o_argB)
  );

  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;

endmodule

// File: doc/exe_frame_rx.md
# exe_frame_rx

Serial command-frame receiver for the SPI execution unit. Collects one frame (opcode, operand A, operand B, MSB first) from the serial input. It then presents the three fields in parallel, under a valid/ready handshake, to the execution stage, whose first step is the U1→U2 operand conversion. Operands are forwarded bit-exact in U1 encoding; no arithmetic is done here.

## Interface
Parameters:
- BITS, 8, operand width (≥2)
- OPC_BITS, 4, opcode width (≥1)

Ports:
- i_clk  in  1  single clock; all logic rising-edge
- i_rst_n  in  1  asynchronous active-low reset
- i_cs_n  in  1  frame select, active low; high = no frame
- i_bit_en  in  1  one-cycle strobe: i_sdi holds a sampled serial bit
- i_sdi  in  1  serial data bit
- o_opcode  out  OPC_BITS  received opcode
- o_argA  out  BITS  received operand A (U1, raw)
- o_argB  out  BITS  received operand B (U1, raw)
- o_valid  out  1  fields valid, held until accepted
- i_ready  in  1  execution stage accepts fields
- o_frame_err  out  1  one-cycle pulse on aborted or overrun frame

## Operation
- Accepted bit = i_bit_en && !i_cs_n at a rising edge; all other cycles ignore i_sdi.
- Frame = OPC_BITS + 2·BITS accepted bits (20 by default): opcode MSB first, then A MSB first, then B MSB first.
- States:
  - IDLE: first accepted bit → OPCODE (bit shifted in, count 1).
  - OPCODE, ARG_A, ARG_B: shift left, LSB ← i_sdi. After the last bit of a field, move to the next state with the counter cleared. The last B bit moves to HOLD.
  - HOLD: o_valid=1. On o_valid && i_ready → IDLE.
- Abort: i_cs_n high while in OPCODE/ARG_A/ARG_B → IDLE, o_frame_err pulse, partial data discarded, o_valid stays 0.
- Overrun: an accepted bit in HOLD without handshake in the same cycle → bit discarded, o_frame_err pulse, state stays HOLD, outputs unchanged.
- Handshake and accepted bit on the same edge: transfer completes, and the bit is taken as opcode bit 1 of a new frame (→ OPCODE, count 1). No error.
- i_cs_n high in HOLD or IDLE: no effect.
- o_opcode/o_argA/o_argB are registered. They change only on the edge that completes a frame, and stay stable from then until the next frame completes.
- Reset (asynchronous, any state including mid-frame): state IDLE, counter 0, o_valid 0, o_frame_err 0, o_opcode/o_argA/o_argB all 0.

## Timing
- o_valid rises in the cycle after the edge that samples the last B bit. Fields are valid in that same cycle.
- Transfer occurs on an edge where o_valid && i_ready. o_valid is low the following cycle unless a new frame completes on that edge, which cannot happen with a frame length > 1.
- i_ready may be high permanently; minimum frame-to-frame time = frame length accepted bits + 0 idle cycles.
- o_frame_err is registered and high exactly one cycle after the offending edge.
- No combinational path from any input to any output.

## Structure
- Package exe_pkg holds:
  - state enum exe_rx_state_t {IDLE, OPCODE, ARG_A, ARG_B, HOLD}
  - default BITS/OPC_BITS constants
  - frame-length function OPC_BITS+2·BITS
- Counter width is $clog2(max(BITS, OPC_BITS)+1).
- One sub-module is natural: exe_sipo, a parameterised serial-in/parallel-out shift register with a load enable, instantiated for the opcode, A and B fields. The FSM and counter stay in exe_frame_rx.

## Test plan
- Nominal frame, i_ready=1: bits of 4'h3, 8'hF5, 8'h07 → one-cycle o_valid with o_opcode=3, o_argA=F5, o_argB=07. o_frame_err stays 0.
- Backpressure: same frame with i_ready=0 for 10 cycles, then 1 → o_valid held 10+ cycles with stable fields, then drops the cycle after the handshake.
- Abort: i_cs_n high after 9 accepted bits → o_frame_err pulse, no o_valid. A following full frame (4'hA, 8'h80, 8'h7F) is received correctly.
- Overrun: frame completes, i_ready=0, 3 more accepted bits → three o_frame_err pulses, fields unchanged.
- Back-to-back: handshake edge coincides with the first bit of the next frame (4'h1, 8'hFF, 8'h00) → both frames delivered, no error.
- Reset mid-frame (after 12 bits) and in HOLD → all outputs 0 immediately. The next frame is decoded from bit 0.
